ps2_dir_receiver: RTL and testbench
===================================

# ps2_dir_receiver

PS/2 keyboard receiver that turns key presses into the 4-bit move request consumed by `controller_game`. It is the input-side counterpart of the display path: it reads the keyboard's serial frames, decodes make/break scancodes for arrow keys and WASD, and issues one single-cycle `dir` pulse per new key press. It sits beside `game2048` on the same `dir` bus, selected at top level, and runs in the 50 MHz `clk` domain.

## Interface
- `FILT`, 8: cycles the synchronized `ps2_clk` must hold a new level before an edge is accepted.
- `TIMEOUT`, 50000: idle cycles between bits after which a partial frame is abandoned (1 ms at 50 MHz).
- `clk`  in  1  system clock, 50 MHz; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  keyboard clock, asynchronous, idle high.
- `ps2_data`  in  1  keyboard data, asynchronous, idle high.
- `dir`  out  4  one-hot move pulse, one cycle wide: bit0 up, bit1 down, bit2 left, bit3 right; 0 otherwise.
- `key_code`  out  8  last correctly framed scancode byte.
- `frame_err`  out  1  one-cycle pulse on parity, stop-bit or timeout error.

## Operation
- Input conditioning: 2-FF synchronizer on both PS/2 lines; glitch filter on `ps2_clk` (level adopted only after `FILT` consecutive equal samples); falling edge of filtered clock = sample strobe.
- Frame FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: strobe with data 0 (start bit) -> DATA, bit count 0; strobe with data 1 ignored.
  - DATA: shift in 8 bits LSB first; after 8th -> PARITY.
  - PARITY: capture bit; -> STOP.
  - STOP: require stop = 1 and odd parity over 8 data bits plus parity bit; pass -> byte valid, `key_code` updated; fail -> `frame_err`. Either way -> IDLE.
  - Timeout counter cleared on every strobe, counts in any state except IDLE; reaching `TIMEOUT` -> `frame_err`, -> IDLE, partial byte dropped.
- Decoder FSM on each valid byte, states D_IDLE, D_EXT, D_BRK, D_EXT_BRK:
  - D_IDLE: E0 -> D_EXT; F0 -> D_BRK; 1D/1B/1C/23 (W/S/A/D) -> make up/down/left/right; other -> stay.
  - D_EXT: F0 -> D_EXT_BRK; 75/72/6B/74 -> make up/down/left/right, -> D_IDLE; other -> D_IDLE.
  - D_BRK: W/S/A/D code -> break of that direction; -> D_IDLE.
  - D_EXT_BRK: arrow code -> break of that direction; -> D_IDLE.
  - Any `frame_err` -> decoder to D_IDLE.
- Held mask `held[3:0]`: make of direction k pulses `dir[k]` only if `held[k]`=0, then sets `held[k]`; break clears it. Typematic repeats produce no pulse. Arrow and WASD of the same direction share one held bit.
- At most one `dir` bit is set in any cycle.

## Timing
- Reset values: `dir`=0, `key_code`=8'h00, `frame_err`=0, both FSMs idle, `held`=0, counters 0, synchronizers and filter preset to 1.
- Latency: sync 2 cycles + filter `FILT` cycles to strobe; STOP strobe -> byte valid/`key_code` next cycle; `dir` pulse one cycle after byte valid.
- `frame_err` asserted the cycle after the failing STOP strobe or timeout terminal count.
- Reset asserted mid-frame: all state cleared immediately; deassertion mid-frame -> bits before the next start bit ignored (the trailing partial frame times out or fails framing and is discarded).
- Strobe on the same cycle as timeout terminal count: timeout wins; strobe discarded.

## Structure
- Shared package `game_pkg`: direction one-hot constants (`DIR_UP`..`DIR_RIGHT`, `DIR_NONE`), scancode constants (`SC_EXT`=E0, `SC_BRK`=F0, arrow and WASD codes), decoder state enum.
- Sub-module `ps2_rx_frame`: synchronizer, filter, frame FSM, timeout; outputs `byte_valid`, `byte_data`, `frame_err`. Top holds decoder FSM and held mask.

## Test plan
- Frame E0 then 75 (10 µs bit period) -> `key_code`=75, `dir`=4'b0001 for exactly one cycle.
- E0 75 sent three times, no break -> single `dir` pulse; then E0 F0 75, E0 75 -> second pulse 4'b0001.
- 1C (A) -> `dir`=4'b0100; F0 1C; E0 6B -> `dir`=4'b0100 again.
- Byte 75 with even parity -> `frame_err` pulse, `key_code` unchanged, no `dir`; next good frame decodes.
- Start bit plus 5 data bits then silence 50000 cycles -> `frame_err`; following E0 74 -> `dir`=4'b1000.
- `rst` low during 4th data bit of E0 -> all outputs 0; after release a clean 72 frame -> `key_code`=72, no `dir` (decoder in D_IDLE, 72 unmapped there).

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game input path.
// Contents:
//   - one-hot move directions consumed by controller_game (DIR_*)
//   - PS/2 set-2 scancodes for the prefix bytes, arrow keys and WASD (SC_*)
//   - frame and decoder state enums
//   - helpers mapping a scancode to its direction (DIR_NONE if unmapped)
package game_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
  typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dec_state_t;

  function automatic logic [3:0] wasd_dir(input logic [7:0] code);
    case (code)
      SC_W:    return DIR_UP;
      SC_S:    return DIR_DOWN;
      SC_A:    return DIR_LEFT;
      SC_D:    return DIR_RIGHT;
      default: return DIR_NONE;
    endcase
  endfunction

  function automatic logic [3:0] arrow_dir(input logic [7:0] code);
    case (code)
      SC_UP:    return DIR_UP;
      SC_DOWN:  return DIR_DOWN;
      SC_LEFT:  return DIR_LEFT;
      SC_RIGHT: return DIR_RIGHT;
      default:  return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_dir_receiver_if.sv
// Bundle of the PS/2 keyboard lines and the decoded outputs of ps2_dir_receiver.
//   ps2_clk, ps2_data : keyboard lines (asynchronous, idle high)
//   dir               : one-hot move pulse (bit0 up, bit1 down, bit2 left, bit3 right)
//   key_code          : last correctly framed scancode byte
//   frame_err         : one-cycle framing/timeout error pulse
// master = the receiver, slave = the keyboard/consumer side.
interface ps2_dir_receiver_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] dir;
  logic [7:0] key_code;
  logic       frame_err;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output dir,
    output key_code,
    output frame_err
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  dir,
    input  key_code,
    input  frame_err
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 serial frame receiver.
// Synchronizes both keyboard lines, glitch-filters ps2_clk, and uses the
// falling edge of the filtered clock as a sample strobe for an 11-bit frame
// (start, 8 data LSB first, odd parity, stop).
// Ports:
//   clk, rst      : system clock, asynchronous active-low reset
//   ps2_clk/data  : raw keyboard lines
//   byte_valid    : one-cycle pulse, a good frame has been received
//   byte_data     : last good byte (updated together with byte_valid)
//   frame_err     : one-cycle pulse on parity/stop error or inter-bit timeout
module ps2_rx_frame
  import game_pkg::*;
#(
  parameter int FILT    = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int FILT_W = $clog2(FILT + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  logic [1:0]        clk_sync_reg;
  logic [1:0]        data_sync_reg;
  logic              filt_level_reg;
  logic [FILT_W-1:0] filt_cnt_reg;
  logic              strobe_reg;
  logic              clk_s;
  logic              data_s;

  assign clk_s  = clk_sync_reg[1];
  assign data_s = data_sync_reg[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
    end
  end

  // A new clock level is adopted only after FILT consecutive samples that
  // differ from the current level; any sample matching it restarts the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_level_reg <= 1'b1;
      filt_cnt_reg   <= '0;
      strobe_reg     <= 1'b0;
    end else begin
      strobe_reg <= 1'b0;
      if (clk_s == filt_level_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FILT_LAST) begin
        filt_level_reg <= clk_s;
        filt_cnt_reg   <= '0;
        strobe_reg     <= ~clk_s;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  frame_state_t     state_reg, state_next;
  logic [2:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic             parity_reg, parity_next;
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             byte_valid_reg, byte_valid_next;
  logic [7:0]       byte_data_reg, byte_data_next;
  logic             frame_err_reg, frame_err_next;
  logic             tmo_tc;

  assign tmo_tc = (state_reg != IDLE) && (tmo_cnt_reg == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_reg     <= 1'b0;
      tmo_cnt_reg    <= '0;
      byte_valid_reg <= 1'b0;
      byte_data_reg  <= '0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      parity_reg     <= parity_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      byte_valid_reg <= byte_valid_next;
      byte_data_reg  <= byte_data_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    parity_next     = parity_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    byte_valid_next = 1'b0;
    byte_data_next  = byte_data_reg;
    frame_err_next  = 1'b0;

    // Timeout has priority: a strobe landing on the terminal count is dropped.
    if (tmo_tc) begin
      state_next     = IDLE;
      tmo_cnt_next   = '0;
      frame_err_next = 1'b1;
    end else if (strobe_reg) begin
      tmo_cnt_next = '0;
      case (state_reg)
        IDLE: begin
          if (!data_s) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          shift_next   = {data_s, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          parity_next = data_s;
          state_next  = STOP;
        end
        STOP: begin
          if (data_s && (^{shift_reg, parity_reg})) begin
            byte_valid_next = 1'b1;
            byte_data_next  = shift_reg;
          end else begin
            frame_err_next = 1'b1;
          end
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (state_reg != IDLE) begin
      tmo_cnt_next = tmo_cnt_reg + 1'b1;
    end else begin
      tmo_cnt_next = '0;
    end
  end

  assign byte_valid = byte_valid_reg;
  assign byte_data  = byte_data_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: rtl/ps2_dir_receiver.sv
// PS/2 keyboard to game move-request converter.
// Decodes make/break scancodes of arrow keys (E0-prefixed) and WASD into
// a single-cycle one-hot dir pulse per new key press. A held mask shared by
// arrow and WASD keys suppresses typematic repeats until the key is released.
// Ports:
//   clk : 50 MHz system clock
//   rst : asynchronous active-low reset
//   bus : ps2_dir_receiver_if.master (ps2_clk/ps2_data in; dir, key_code,
//         frame_err out)
module ps2_dir_receiver
  import game_pkg::*;
#(
  parameter int FILT    = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic                clk,
  input  logic                rst,
  ps2_dir_receiver_if.master  bus
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  ps2_rx_frame #(
    .FILT    (FILT),
    .TIMEOUT (TIMEOUT)
  ) u_frame (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (bus.ps2_clk),
    .ps2_data   (bus.ps2_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  dec_state_t dec_reg, dec_next;
  logic [3:0] held_reg, held_next;
  logic [3:0] dir_reg, dir_next;
  logic [3:0] make_dir;
  logic [3:0] brk_dir;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_reg  <= D_IDLE;
      held_reg <= '0;
      dir_reg  <= DIR_NONE;
    end else begin
      dec_reg  <= dec_next;
      held_reg <= held_next;
      dir_reg  <= dir_next;
    end
  end

  always_comb begin
    dec_next = dec_reg;
    make_dir = DIR_NONE;
    brk_dir  = DIR_NONE;

    if (frame_err) begin
      dec_next = D_IDLE;
    end else if (byte_valid) begin
      case (dec_reg)
        D_IDLE: begin
          if (byte_data == SC_EXT)      dec_next = D_EXT;
          else if (byte_data == SC_BRK) dec_next = D_BRK;
          else                          make_dir = wasd_dir(byte_data);
        end
        D_EXT: begin
          if (byte_data == SC_BRK) begin
            dec_next = D_EXT_BRK;
          end else begin
            make_dir = arrow_dir(byte_data);
            dec_next = D_IDLE;
          end
        end
        D_BRK: begin
          brk_dir  = wasd_dir(byte_data);
          dec_next = D_IDLE;
        end
        D_EXT_BRK: begin
          brk_dir  = arrow_dir(byte_data);
          dec_next = D_IDLE;
        end
        default: dec_next = D_IDLE;
      endcase
    end

    // make_dir is at most one-hot, so dir can never carry two bits.
    dir_next  = make_dir & ~held_reg;
    held_next = (held_reg | make_dir) & ~brk_dir;
  end

  assign bus.dir       = dir_reg;
  assign bus.key_code  = byte_data;
  assign bus.frame_err = frame_err;

endmodule

// File: tb/tb_ps2_dir_receiver.sv
module tb_ps2_dir_receiver;

  localparam int HALF = 20;    // half PS/2 bit period in system clocks
  localparam int TMO  = 3000;  // shortened timeout to keep the run short

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  ps2_dir_receiver_if bus();

  ps2_dir_receiver #(.FILT(8), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Output monitor
  int         dir_pulses = 0;
  int         err_pulses = 0;
  int         onehot_bad = 0;
  logic [3:0] last_dir = 4'h0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.dir != 4'h0) begin
        dir_pulses++;
        last_dir = bus.dir;
        if ($countones(bus.dir) != 1) onehot_bad++;
      end
      if (bus.frame_err) err_pulses++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: prefix flags plus a per-direction held flag.
  logic       m_ext, m_brk;
  logic [3:0] m_held;
  logic [7:0] m_key;

  function automatic int dir_index(input logic ext, input logic [7:0] b);
    logic [7:0] tbl [4];
    if (ext) tbl = '{8'h75, 8'h72, 8'h6B, 8'h74};
    else     tbl = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    for (int i = 0; i < 4; i++) if (tbl[i] == b) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = 4'h0; m_key = 8'h00;
  endtask

  task automatic model_apply(input logic [7:0] b, input bit bad,
                             output logic [3:0] ed, output bit ee);
    int k;
    ed = 4'h0;
    ee = bad;
    if (bad) begin
      m_ext = 0; m_brk = 0;
      return;
    end
    m_key = b;
    if (b == 8'hE0 && !m_ext && !m_brk) m_ext = 1;
    else if (b == 8'hF0 && !m_brk) m_brk = 1;
    else begin
      k = dir_index(m_ext, b);
      if (k >= 0) begin
        if (m_brk) m_held[k] = 1'b0;
        else if (!m_held[k]) begin
          ed = 4'(1 << k);
          m_held[k] = 1'b1;
        end
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  // PS/2 line driver: data changes while ps2_clk is high, sampled on fall.
  task automatic send_bit(input logic v);
    bus.ps2_data = v;
    repeat (HALF) @(posedge clk);
    bus.ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] bits;
    bits = {1'b1, (bad_par ? ^b : ~^b), b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i]);
    bus.ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
  endtask

  task automatic do_frame(input string name, input logic [7:0] b, input bit bad,
                          input logic [7:0] exp_key, input logic [3:0] exp_dir,
                          input bit exp_err);
    int d0, e0;
    d0 = dir_pulses;
    e0 = err_pulses;
    send_frame(b, bad);
    @(posedge clk); #1;
    $display("frame %s byte=%02h bad=%0d key=%02h dir=%b err_pulses=%0d",
             name, b, bad, bus.key_code, last_dir, err_pulses - e0);
    chk({name, "_key"}, 32'(bus.key_code), 32'(exp_key));
    chk({name, "_npulse"}, 32'(dir_pulses - d0), (exp_dir != 4'h0) ? 32'd1 : 32'd0);
    if (exp_dir != 4'h0) chk({name, "_dir"}, 32'(last_dir), 32'(exp_dir));
    chk({name, "_err"}, 32'(err_pulses - e0), 32'(exp_err));
  endtask

  typedef struct {
    logic [7:0] code;
    bit         bad;
    logic [7:0] key;
    logic [3:0] dir;
    bit         err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [3:0] ed;
    bit         ee;
    logic [7:0] b;
    logic [7:0] pool [10];
    int         d0, e0, sel;
    logic [7:0] e0_byte;

    vecs.push_back('{8'hE0, 1'b0, 8'hE0, 4'b0000, 1'b0});
    vecs.push_back('{8'h75, 1'b0, 8'h75, 4'b0001, 1'b0});
    vecs.push_back('{8'hE0, 1'b0, 8'hE0, 4'b0000, 1'b0});
    vecs.push_back('{8'h75, 1'b0, 8'h75, 4'b0000, 1'b0});
    vecs.push_back('{8'hE0, 1'b0, 8'hE0, 4'b0000, 1'b0});
    vecs.push_back('{8'h75, 1'b0, 8'h75, 4'b0000, 1'b0});
    vecs.push_back('{8'hE0, 1'b0, 8'hE0, 4'b0000, 1'b0});
    vecs.push_back('{8'hF0, 1'b0, 8'hF0, 4'b0000, 1'b0});
    vecs.push_back('{8'h75, 1'b0, 8'h75, 4'b0000, 1'b0});
    vecs.push_back('{8'hE0, 1'b0, 8'hE0, 4'b0000, 1'b0});
    vecs.push_back('{8'h75, 1'b0, 8'h75, 4'b0001, 1'b0});
    vecs.push_back('{8'h1C, 1'b0, 8'h1C, 4'b0100, 1'b0});
    vecs.push_back('{8'hF0, 1'b0, 8'hF0, 4'b0000, 1'b0});
    vecs.push_back('{8'h1C, 1'b0, 8'h1C, 4'b0000, 1'b0});
    vecs.push_back('{8'hE0, 1'b0, 8'hE0, 4'b0000, 1'b0});
    vecs.push_back('{8'h6B, 1'b0, 8'h6B, 4'b0100, 1'b0});
    vecs.push_back('{8'h75, 1'b1, 8'h6B, 4'b0000, 1'b1});
    vecs.push_back('{8'h1B, 1'b0, 8'h1B, 4'b0010, 1'b0});
    vecs.push_back('{8'h1B, 1'b0, 8'h1B, 4'b0000, 1'b0});

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    chk("reset_dir", 32'(bus.dir), 32'h0);
    chk("reset_key", 32'(bus.key_code), 32'h0);
    chk("reset_err", 32'(bus.frame_err), 32'h0);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    // Directed table; the model tracks along so random traffic starts in sync.
    foreach (vecs[i]) begin
      model_apply(vecs[i].code, vecs[i].bad, ed, ee);
      do_frame($sformatf("vec%0d", i), vecs[i].code, vecs[i].bad,
               vecs[i].key, vecs[i].dir, vecs[i].err);
    end

    // Partial frame (start + 5 data bits) then silence -> timeout error.
    d0 = dir_pulses;
    e0 = err_pulses;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    bus.ps2_data = 1'b1;
    repeat (TMO + 200) @(posedge clk);
    #1;
    $display("timeout partial frame err_pulses=%0d key=%02h", err_pulses - e0, bus.key_code);
    chk("tmo_err", 32'(err_pulses - e0), 32'd1);
    chk("tmo_npulse", 32'(dir_pulses - d0), 32'd0);
    chk("tmo_key", 32'(bus.key_code), 32'h1B);
    model_apply(8'h00, 1'b1, ed, ee);
    model_apply(8'hE0, 1'b0, ed, ee);
    do_frame("tmo_e0", 8'hE0, 1'b0, 8'hE0, 4'b0000, 1'b0);
    model_apply(8'h74, 1'b0, ed, ee);
    do_frame("tmo_74", 8'h74, 1'b0, 8'h74, 4'b1000, 1'b0);

    // Randomized traffic against the model.
    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0};
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 13));
      if (sel < 10) b = pool[sel];
      else          b = 8'($urandom);
      model_apply(b, (sel == 13), ed, ee);
      do_frame($sformatf("rnd%0d", n), b, (sel == 13), m_key, ed, ee);
    end

    // Reset in the middle of the 4th data bit of an E0 frame.
    e0_byte = 8'hE0;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(e0_byte[i]);
    bus.ps2_data = e0_byte[3];
    repeat (HALF) @(posedge clk);
    bus.ps2_clk = 1'b0;
    repeat (5) @(posedge clk);
    rst = 1'b0;
    #1;
    $display("midframe reset dir=%b key=%02h err=%b", bus.dir, bus.key_code, bus.frame_err);
    chk("mrst_dir", 32'(bus.dir), 32'h0);
    chk("mrst_key", 32'(bus.key_code), 32'h0);
    chk("mrst_err", 32'(bus.frame_err), 32'h0);
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    rst = 1'b1;
    model_reset();
    model_apply(8'h72, 1'b0, ed, ee);
    do_frame("post_72", 8'h72, 1'b0, 8'h72, 4'b0000, 1'b0);
    model_apply(8'h1D, 1'b0, ed, ee);
    do_frame("post_w", 8'h1D, 1'b0, 8'h1D, 4'b0001, 1'b0);

    chk("onehot_violations", 32'(onehot_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
